// File: rtl/seq_ctrl_pkg.sv
// Shared types for the multi-cycle CPU sequencer: mode and stage encodings.
package seq_ctrl_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned STAGE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_RUN  = 2'd2,
    MODE_HALT = 2'd3
  } mode_t;

  typedef enum logic [STAGE_W-1:0] {
    STAGE_FETCH    = 3'd0,
    STAGE_DECODE   = 3'd1,
    STAGE_EXECUTE  = 3'd2,
    STAGE_WRITEREG = 3'd3
  } stage_t;

endpackage

// File: rtl/seq_ctrl_perf_cnt.sv
// Free-running performance counter with synchronous clear and count enable.
module perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Wraps modulo 2^CNT_W without saturation.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle CPU sequencer: boot/load handshake, FETCH/DECODE/EXECUTE/WRITEREG loop,
// single-step, halt/resume, I/O-wait watchdog and performance counters.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     LAT_W    = 5,
  parameter int unsigned     CNT_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               boot_req,
  input  logic               load_done,
  input  logic               load_ack,
  input  logic [PC_W-1:0]    d_npc,
  input  logic [LAT_W-1:0]   de_wait_time,
  input  logic               de_stop,
  input  logic               io_busy,
  input  logic               step_mode,
  input  logic               step_req,
  input  logic               resume,
  output logic [PC_W-1:0]    pc,
  output logic [MODE_W-1:0]  mode,
  output logic [STAGE_W-1:0] stage,
  output logic               fd_update,
  output logic               de_update,
  output logic               ew_update,
  output logic               e_start,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  mode_t            mode_q, mode_d;
  stage_t           stage_q, stage_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
  logic             e_start_q, e_start_d;
  logic             timeout_q, timeout_d;
  logic             go;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_IDLE;
      stage_q   <= STAGE_FETCH;
      pc_q      <= RESET_PC;
      lat_q     <= '0;
      wd_q      <= '0;
      e_start_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      stage_q   <= stage_d;
      pc_q      <= pc_d;
      lat_q     <= lat_d;
      wd_q      <= wd_d;
      e_start_q <= e_start_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic for mode and stage FSMs.
  always_comb begin
    mode_d    = mode_q;
    stage_d   = stage_q;
    pc_d      = pc_q;
    lat_d     = lat_q;
    wd_d      = wd_q;
    e_start_d = e_start_q;
    timeout_d = timeout_q;
    go        = !step_mode || step_req;
    wd_inc    = wd_q + WD_W'(1);

    case (mode_q)
      MODE_IDLE: begin
        if (boot_req) mode_d = MODE_LOAD;
      end
      MODE_LOAD: begin
        if (load_done && load_ack) begin
          mode_d  = MODE_RUN;
          stage_d = STAGE_FETCH;
        end
      end
      MODE_RUN: begin
        case (stage_q)
          STAGE_FETCH: begin
            if (go) stage_d = STAGE_DECODE;
          end
          STAGE_DECODE: begin
            stage_d   = STAGE_EXECUTE;
            pc_d      = d_npc;
            e_start_d = 1'b1;
            lat_d     = '0;
            wd_d      = '0;
          end
          STAGE_EXECUTE: begin
            e_start_d = 1'b0;
            // >= so a wait time lowered mid-instruction cannot strand the counter.
            if (lat_q < de_wait_time) begin
              lat_d = lat_q + LAT_W'(1);
            end else if (!io_busy) begin
              lat_d   = '0;
              wd_d    = '0;
              stage_d = STAGE_WRITEREG;
            end else if (TIMEOUT != 0) begin
              if (wd_inc == WD_W'(TIMEOUT)) begin
                timeout_d = 1'b1;
                lat_d     = '0;
                wd_d      = '0;
                stage_d   = STAGE_WRITEREG;
              end else begin
                wd_d = wd_inc;
              end
            end
          end
          STAGE_WRITEREG: begin
            stage_d = STAGE_FETCH;
            if (de_stop) mode_d = MODE_HALT;
          end
          default: stage_d = STAGE_FETCH;
        endcase
      end
      MODE_HALT: begin
        if (resume) begin
          mode_d  = MODE_RUN;
          stage_d = STAGE_FETCH;
          pc_d    = RESET_PC;
        end
      end
      default: mode_d = MODE_IDLE;
    endcase
  end

  assign pc        = pc_q;
  assign mode      = mode_q;
  assign stage     = stage_q;
  assign e_start   = e_start_q;
  assign timeout   = timeout_q;
  assign fd_update = (mode_q == MODE_RUN) && (stage_q == STAGE_FETCH) && go;
  assign de_update = (mode_q == MODE_RUN) && (stage_q == STAGE_DECODE);
  assign ew_update = (mode_q == MODE_RUN) && (stage_q == STAGE_WRITEREG);

  perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (mode_q == MODE_RUN),
    .count (cycle_cnt)
  );

  perf_cnt #(.CNT_W(CNT_W)) u_instret (
    .clk   (clk),
    .clr   (rst),
    .en    ((mode_q == MODE_RUN) && (stage_q == STAGE_WRITEREG)),
    .count (instret)
  );

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: boot table plus watchdog, reset, step and halt sequences.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, boot_req, load_done, load_ack;
  logic [31:0] d_npc;
  logic [4:0]  de_wait_time;
  logic        de_stop, io_busy, step_mode, step_req, resume;
  logic [31:0] pc;
  logic [1:0]  mode;
  logic [2:0]  stage;
  logic        fd_update, de_update, ew_update, e_start, timeout;
  logic [31:0] cycle_cnt, instret;

  int nvec = 0;
  int nbad = 0;

  seq_ctrl #(
    .PC_W(32), .LAT_W(5), .CNT_W(32), .RESET_PC(32'd0), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst), .boot_req(boot_req), .load_done(load_done),
    .load_ack(load_ack), .d_npc(d_npc), .de_wait_time(de_wait_time),
    .de_stop(de_stop), .io_busy(io_busy), .step_mode(step_mode),
    .step_req(step_req), .resume(resume), .pc(pc), .mode(mode), .stage(stage),
    .fd_update(fd_update), .de_update(de_update), .ew_update(ew_update),
    .e_start(e_start), .timeout(timeout), .cycle_cnt(cycle_cnt), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b, l, a;
    int   m, s, p, f, d, e, es, ir, cyc;
  } vec_t;

  function automatic vec_t mk(logic b, logic l, logic a, int m, int s, int p,
                              int f, int d, int e, int es, int ir, int cyc);
    vec_t v;
    v.b = b; v.l = l; v.a = a; v.m = m; v.s = s; v.p = p;
    v.f = f; v.d = d; v.e = e; v.es = es; v.ir = ir; v.cyc = cyc;
    return v;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stage(input int target, input int budget);
    int k = 0;
    while (32'(stage) != target && k < budget) begin
      tick();
      k++;
    end
    chk("wait_stage", 64'(stage), 64'(target));
  endtask

  task automatic boot();
    boot_req = 1'b1; #1; tick();
    boot_req = 1'b0; load_done = 1'b1; load_ack = 1'b1; tick();
    load_done = 1'b0; load_ack = 1'b0; #1;
    chk("reboot_mode", 64'(mode), 64'(2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

  vec_t tbl[13];
  int   n;
  int   bad;

  initial begin
    rst = 1'b1; boot_req = 0; load_done = 0; load_ack = 0; d_npc = 32'd4;
    de_wait_time = 5'd3; de_stop = 0; io_busy = 0; step_mode = 0; step_req = 0;
    resume = 0;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_mode", 64'(mode), 64'(0));
    chk("rst_stage", 64'(stage), 64'(0));
    chk("rst_pc", 64'(pc), 64'(0));
    chk("rst_estart", 64'(e_start), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));

    // Boot with load_ack lagging load_done by 3 cycles, then one dwt=3 instruction.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 2, 1, 0, 0, 1, 0, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0, 2, 2, 4, 0, 0, 0, 1, 0, 2);
    tbl[8]  = mk(0, 0, 0, 2, 2, 4, 0, 0, 0, 0, 0, 3);
    tbl[9]  = mk(0, 0, 0, 2, 2, 4, 0, 0, 0, 0, 0, 4);
    tbl[10] = mk(0, 0, 0, 2, 2, 4, 0, 0, 0, 0, 0, 5);
    tbl[11] = mk(0, 0, 0, 2, 3, 4, 0, 0, 1, 0, 0, 6);
    tbl[12] = mk(0, 0, 0, 2, 0, 4, 1, 0, 0, 0, 1, 7);

    for (int i = 0; i < 13; i++) begin
      boot_req = tbl[i].b; load_done = tbl[i].l; load_ack = tbl[i].a;
      #1;
      chk($sformatf("v%0d_mode", i), 64'(mode), 64'(tbl[i].m));
      chk($sformatf("v%0d_stage", i), 64'(stage), 64'(tbl[i].s));
      chk($sformatf("v%0d_pc", i), 64'(pc), 64'(tbl[i].p));
      chk($sformatf("v%0d_fd", i), 64'(fd_update), 64'(tbl[i].f));
      chk($sformatf("v%0d_de", i), 64'(de_update), 64'(tbl[i].d));
      chk($sformatf("v%0d_ew", i), 64'(ew_update), 64'(tbl[i].e));
      chk($sformatf("v%0d_estart", i), 64'(e_start), 64'(tbl[i].es));
      chk($sformatf("v%0d_instret", i), 64'(instret), 64'(tbl[i].ir));
      chk($sformatf("v%0d_cycle", i), 64'(cycle_cnt), 64'(tbl[i].cyc));
      tick();
    end

    // Watchdog expiry: io_busy held through EXECUTE (now in DECODE).
    de_wait_time = 5'd0; io_busy = 1'b1; d_npc = 32'd8;
    tick();
    chk("wd_pc", 64'(pc), 64'(8));
    chk("wd_timeout_pre", 64'(timeout), 64'(0));
    n = 0;
    while (stage == 3'd2 && n < 40) begin
      n++;
      tick();
    end
    chk("wd_exec_cycles", 64'(n), 64'(10));
    chk("wd_stage", 64'(stage), 64'(3));
    chk("wd_timeout", 64'(timeout), 64'(1));
    io_busy = 1'b0;
    tick();
    chk("wd_instret", 64'(instret), 64'(2));
    tick(); tick(); tick(); tick();
    chk("wd_next_stage", 64'(stage), 64'(0));
    chk("wd_next_instret", 64'(instret), 64'(3));
    chk("wd_sticky", 64'(timeout), 64'(1));

    // Reset with the latency counter at 2.
    de_wait_time = 5'd5;
    tick(); tick(); tick(); tick();
    chk("mid_stage", 64'(stage), 64'(2));
    rst = 1'b1; #1; tick();
    rst = 1'b0; #1;
    chk("mid_mode", 64'(mode), 64'(0));
    chk("mid_stage_rst", 64'(stage), 64'(0));
    chk("mid_pc", 64'(pc), 64'(0));
    chk("mid_estart", 64'(e_start), 64'(0));
    chk("mid_timeout", 64'(timeout), 64'(0));
    chk("mid_cycle", 64'(cycle_cnt), 64'(0));
    chk("mid_instret", 64'(instret), 64'(0));
    chk("mid_fd", 64'(fd_update), 64'(0));

    // io_busy drops on the 10th busy cycle: normal completion.
    boot();
    de_wait_time = 5'd0; io_busy = 1'b1;
    tick(); tick();
    n = 0;
    while (stage == 3'd2 && n < 40) begin
      n++;
      if (n == 10) io_busy = 1'b0;
      tick();
    end
    chk("drop_exec_cycles", 64'(n), 64'(10));
    chk("drop_stage", 64'(stage), 64'(3));
    chk("drop_timeout", 64'(timeout), 64'(0));
    tick();
    chk("drop_instret", 64'(instret), 64'(1));

    // Single-step: hold 50 cycles, then release exactly one instruction.
    step_mode = 1'b1; #1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (stage != 3'd0 || fd_update != 1'b0) bad++;
    end
    chk("step_hold", 64'(bad), 64'(0));
    step_req = 1'b1; #1;
    chk("step_fd", 64'(fd_update), 64'(1));
    tick();
    step_req = 1'b0; #1;
    chk("step_decode", 64'(stage), 64'(1));
    wait_stage(0, 20);
    chk("step_instret", 64'(instret), 64'(2));
    for (int i = 0; i < 5; i++) tick();
    chk("step_stall_stage", 64'(stage), 64'(0));
    chk("step_stall_instret", 64'(instret), 64'(2));

    // Halt, ignored inputs in HALT, then resume.
    step_mode = 1'b0; de_stop = 1'b1; d_npc = 32'd12;
    tick(); tick(); tick();
    chk("halt_ew", 64'(ew_update), 64'(1));
    tick();
    chk("halt_mode", 64'(mode), 64'(3));
    chk("halt_instret", 64'(instret), 64'(3));
    chk("halt_cycle", 64'(cycle_cnt), 64'(76));
    boot_req = 1'b1; step_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    boot_req = 1'b0; step_req = 1'b0; #1;
    chk("halt_hold_mode", 64'(mode), 64'(3));
    chk("halt_frozen_cycle", 64'(cycle_cnt), 64'(76));
    chk("halt_frozen_pc", 64'(pc), 64'(12));
    chk("halt_fd", 64'(fd_update), 64'(0));
    resume = 1'b1; #1; tick();
    resume = 1'b0; de_stop = 1'b0; #1;
    chk("resume_mode", 64'(mode), 64'(2));
    chk("resume_pc", 64'(pc), 64'(0));
    chk("resume_stage", 64'(stage), 64'(0));
    chk("resume_instret", 64'(instret), 64'(3));
    chk("resume_cycle", 64'(cycle_cnt), 64'(76));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
